// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/nop sequencing for the 5-stage WISC-SP22 pipeline
// Ports:
//   clk_i, rst_i (sync, active-low)
//   id_rs_i/id_rt_i (+_vld_i): ID sources; ex_wr_reg_i/ex_memread_i: EX load destination
//   ex_redirect_i: taken branch/jump in EX; imem_stall_i/dmem_stall_i: memory busy
//   wb_halt_i: HALT in WB
//   *_stall_o: hold pipeline registers; ifid_flush_o/idex_nop_o/memwb_nop_o: bubble insertion
//   halted_o, state_o (RUN/LU/DWAIT/HALT), stall_cnt_o/flush_cnt_o: saturating event counters
module pipe_hazard_ctrl #(
    parameter int LU_CYC = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       id_rs_i,
    input  logic [2:0]       id_rt_i,
    input  logic             id_rs_vld_i,
    input  logic             id_rt_vld_i,
    input  logic [2:0]       ex_wr_reg_i,
    input  logic             ex_memread_i,
    input  logic             ex_redirect_i,
    input  logic             imem_stall_i,
    input  logic             dmem_stall_i,
    input  logic             wb_halt_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             idex_stall_o,
    output logic             exmem_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_nop_o,
    output logic             memwb_nop_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, DWAIT = 2'd2, HALT = 2'd3} state_t;
    localparam logic [1:0] LU_LOAD = 2'(LU_CYC - 1);
    state_t           state_q, state_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu_hit, flush_inc;
    assign lu_hit = ex_memread_i & ((id_rs_vld_i & (id_rs_i == ex_wr_reg_i)) |
                                    (id_rt_vld_i & (id_rt_i == ex_wr_reg_i)));
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        idex_stall_o  = 1'b0;
        exmem_stall_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_nop_o    = 1'b0;
        memwb_nop_o   = 1'b0;
        halted_o      = 1'b0;
        flush_inc     = 1'b0;
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        rd_pend_d     = rd_pend_q;
        if (!rst_i) begin
            ifid_flush_o = 1'b1;
            idex_nop_o   = 1'b1;
            memwb_nop_o  = 1'b1;
        end else if (state_q == HALT) begin
            {pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o} = 4'b1111;
            idex_nop_o  = 1'b1;
            memwb_nop_o = 1'b1;
            halted_o    = 1'b1;
        end else if (dmem_stall_i) begin
            {pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o} = 4'b1111;
            memwb_nop_o = 1'b1;
            state_d     = DWAIT;
        end else begin
            // DWAIT falls through here and acts like RUN; a frozen countdown resumes via lu_cnt
            if (ex_redirect_i) begin
                ifid_flush_o = 1'b1;
                idex_nop_o   = 1'b1;
                lu_cnt_d     = 2'd0;
                rd_pend_d    = imem_stall_i;
                flush_inc    = 1'b1;
            end else if (rd_pend_q && !imem_stall_i) begin
                // redirect deferred by a fetch stall: squash the stale fetch now
                ifid_flush_o = 1'b1;
                rd_pend_d    = 1'b0;
                flush_inc    = 1'b1;
            end else if (state_q == LU || lu_hit) begin
                pc_stall_o   = 1'b1;
                ifid_stall_o = 1'b1;
                idex_nop_o   = 1'b1;
                lu_cnt_d     = (state_q == LU) ? lu_cnt_q - 2'd1 : LU_LOAD;
            end else if (imem_stall_i) begin
                // with a redirect pending the PC must load the target, not hold
                pc_stall_o   = !rd_pend_q;
                ifid_flush_o = 1'b1;
            end
            state_d = wb_halt_i ? HALT : ((lu_cnt_d != 2'd0) ? LU : RUN);
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            lu_cnt_q    <= 2'd0;
            rd_pend_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lu_cnt_q  <= lu_cnt_d;
            rd_pend_q <= rd_pend_d;
            if (pc_stall_o && state_q != HALT && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (LU_CYC=1/CNT_W=16 and LU_CYC=2/CNT_W=8)
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_wr_reg;
  logic       id_rs_vld, id_rt_vld, ex_memread, ex_redirect, imem_stall, dmem_stall, wb_halt;
  logic [9:0]  a_ctl, b_ctl;
  logic [15:0] a_sc, a_fc;
  logic [7:0]  b_sc, b_fc;
  localparam logic [9:0] IDLE    = 10'b0000_0000_00;
  localparam logic [9:0] RSTR    = 10'b0000_1110_00;
  localparam logic [9:0] RSTH    = 10'b0000_1110_11;
  localparam logic [9:0] LUB0    = 10'b1100_0100_00;
  localparam logic [9:0] LUB1    = 10'b1100_0100_01;
  localparam logic [9:0] RDR     = 10'b0000_1100_00;
  localparam logic [9:0] RDR_DW  = 10'b0000_1100_10;
  localparam logic [9:0] FLO     = 10'b0000_1000_00;
  localparam logic [9:0] IMS     = 10'b1000_1000_00;
  localparam logic [9:0] FRZ_RUN = 10'b1111_0010_00;
  localparam logic [9:0] FRZ_LU  = 10'b1111_0010_01;
  localparam logic [9:0] FRZ_DW  = 10'b1111_0010_10;
  localparam logic [9:0] DWT     = 10'b0000_0000_10;
  localparam logic [9:0] HLT     = 10'b1111_0111_11;
  localparam bit A = 1'b0, B = 1'b1;
  pipe_hazard_ctrl #(.LU_CYC(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_vld_i(id_rs_vld), .id_rt_vld_i(id_rt_vld), .ex_wr_reg_i(ex_wr_reg),
    .ex_memread_i(ex_memread), .ex_redirect_i(ex_redirect), .imem_stall_i(imem_stall),
    .dmem_stall_i(dmem_stall), .wb_halt_i(wb_halt),
    .pc_stall_o(a_ctl[9]), .ifid_stall_o(a_ctl[8]), .idex_stall_o(a_ctl[7]), .exmem_stall_o(a_ctl[6]),
    .ifid_flush_o(a_ctl[5]), .idex_nop_o(a_ctl[4]), .memwb_nop_o(a_ctl[3]), .halted_o(a_ctl[2]),
    .state_o(a_ctl[1:0]), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));
  pipe_hazard_ctrl #(.LU_CYC(2), .CNT_W(8)) u_b (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_vld_i(id_rs_vld), .id_rt_vld_i(id_rt_vld), .ex_wr_reg_i(ex_wr_reg),
    .ex_memread_i(ex_memread), .ex_redirect_i(ex_redirect), .imem_stall_i(imem_stall),
    .dmem_stall_i(dmem_stall), .wb_halt_i(wb_halt),
    .pc_stall_o(b_ctl[9]), .ifid_stall_o(b_ctl[8]), .idex_stall_o(b_ctl[7]), .exmem_stall_o(b_ctl[6]),
    .ifid_flush_o(b_ctl[5]), .idex_nop_o(b_ctl[4]), .memwb_nop_o(b_ctl[3]), .halted_o(b_ctl[2]),
    .state_o(b_ctl[1:0]), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc));
  typedef struct {
    bit         sel;
    logic [9:0] ctl;
    int         sc;
    int         fc;
    string      name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [9:0] g_ctl;
  int g_sc, g_fc;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      g_ctl = e.sel ? b_ctl : a_ctl;
      g_sc  = e.sel ? int'(b_sc) : int'(a_sc);
      g_fc  = e.sel ? int'(b_fc) : int'(a_fc);
      checks++;
      if (g_ctl !== e.ctl || g_sc != e.sc || g_fc != e.fc) begin
        errors++;
        $display("FAIL %s: got ctl %b stall_cnt %0d flush_cnt %0d, expected ctl %b stall_cnt %0d flush_cnt %0d",
                 e.name, g_ctl, g_sc, g_fc, e.ctl, e.sc, e.fc);
      end
    end
  end
  task automatic ex(input bit sel, input string name, input logic [9:0] ctl, input int sc, input int fc);
    q.push_back('{sel, ctl, sc, fc, name});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    {id_rs, id_rt, ex_wr_reg} = '0;
    {id_rs_vld, id_rt_vld, ex_memread, ex_redirect, imem_stall, dmem_stall, wb_halt} = '0;
  endtask
  task automatic ld(input logic [2:0] rd, input logic [2:0] rs, input logic rsv,
                    input logic [2:0] rt, input logic rtv);
    clr();
    ex_memread = 1'b1;
    ex_wr_reg  = rd;
    id_rs      = rs;
    id_rs_vld  = rsv;
    id_rt      = rt;
    id_rt_vld  = rtv;
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    clr();
    rst = 1'b0;
    tick();
    ex(A, "reset", RSTR, 0, 0); ex(B, "reset_b", RSTR, 0, 0); tick();
    rst = 1'b1;
    ex(A, "idle", IDLE, 0, 0); tick();
    ld(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    ex(A, "lu1_bubble", LUB0, 0, 0); ex(B, "lu2_first", LUB0, 0, 0); tick();
    clr(); id_rs = 3'd3; id_rs_vld = 1'b1;
    ex(A, "lu1_done", IDLE, 1, 0); ex(B, "lu2_second", LUB1, 1, 0); tick();
    clr();
    ex(A, "post_lu", IDLE, 1, 0); ex(B, "lu2_done", IDLE, 2, 0); tick();
    ld(3'd3, 3'd3, 1'b0, 3'd5, 1'b1);
    ex(A, "rs_not_read", IDLE, 1, 0); ex(B, "rs_not_read_b", IDLE, 2, 0); tick();
    ld(3'd0, 3'd7, 1'b1, 3'd0, 1'b1);
    ex(A, "r0_via_rt", LUB0, 1, 0); ex(B, "r0_via_rt_b", LUB0, 2, 0); tick();
    clr();
    ex(A, "r0_done", IDLE, 2, 0); ex(B, "r0_lu_b", LUB1, 3, 0); tick();
    ld(3'd3, 3'd3, 1'b1, 3'd0, 1'b0); ex_redirect = 1'b1;
    ex(A, "redir_over_lu", RDR, 2, 0); ex(B, "redir_over_lu_b", RDR, 4, 0); tick();
    clr();
    ex(A, "post_redir", IDLE, 2, 1); ex(B, "post_redir_b", IDLE, 4, 1); tick();
    ex_redirect = 1'b1; imem_stall = 1'b1;
    ex(A, "redir_imem", RDR, 2, 1); tick();
    ex_redirect = 1'b0;
    ex(A, "rd_pend_1", FLO, 2, 2); tick();
    ex(A, "rd_pend_2", FLO, 2, 2); tick();
    imem_stall = 1'b0;
    ex(A, "deferred_flush", FLO, 2, 2); tick();
    ex(A, "rd_pend_clear", IDLE, 2, 3); tick();
    imem_stall = 1'b1;
    ex(A, "imem_only", IMS, 2, 3); tick();
    imem_stall = 1'b0;
    ex(A, "post_imem", IDLE, 3, 3); ex(B, "post_imem_b", IDLE, 5, 3); tick();
    ld(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    ex(A, "frz_lu_start", LUB0, 3, 3); ex(B, "frz_lu_start_b", LUB0, 5, 3); tick();
    clr(); dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex(A, "freeze", (i == 0) ? FRZ_RUN : FRZ_DW, 4 + i, 3);
      ex(B, "freeze_b", (i == 0) ? FRZ_LU : FRZ_DW, 6 + i, 3);
      tick();
    end
    dmem_stall = 1'b0;
    ex(A, "dwait_exit", DWT, 8, 3); ex(B, "dwait_exit_b", DWT, 10, 3); tick();
    ex(A, "after_dwait", IDLE, 8, 3); ex(B, "lu_resume_b", LUB1, 10, 3); tick();
    ex(A, "settled", IDLE, 8, 3); ex(B, "lu_end_b", IDLE, 11, 3); tick();
    dmem_stall = 1'b1; ex_redirect = 1'b1;
    ex(A, "freeze_beats_redir", FRZ_RUN, 8, 3); ex(B, "freeze_beats_redir_b", FRZ_RUN, 11, 3); tick();
    dmem_stall = 1'b0;
    ex(A, "redir_after_freeze", RDR_DW, 9, 3); ex(B, "redir_after_freeze_b", RDR_DW, 12, 3); tick();
    ex_redirect = 1'b0;
    ex(A, "post_freeze_redir", IDLE, 9, 4); ex(B, "post_freeze_redir_b", IDLE, 12, 4); tick();
    wb_halt = 1'b1;
    ex(A, "halt_request", IDLE, 9, 4); tick();
    wb_halt = 1'b0;
    ex(A, "halted", HLT, 9, 4); ex(B, "halted_b", HLT, 12, 4); tick();
    dmem_stall = 1'b1; ex_redirect = 1'b1; imem_stall = 1'b1;
    ex(A, "halt_absorbing", HLT, 9, 4); tick();
    clr(); rst = 1'b0;
    ex(A, "reset_in_halt", RSTH, 9, 4); tick();
    rst = 1'b1;
    ex(A, "run_after_reset", IDLE, 0, 0); ex(B, "run_after_reset_b", IDLE, 0, 0); tick();
    imem_stall = 1'b1;
    repeat (300) tick();
    imem_stall = 1'b0;
    ex(A, "count_300", IDLE, 300, 0); ex(B, "saturate", IDLE, 255, 0); tick();
    imem_stall = 1'b1;
    ex(B, "saturate_stall", IMS, 255, 0); tick();
    imem_stall = 1'b0;
    ex(A, "count_301", IDLE, 301, 0); ex(B, "saturate_hold", IDLE, 255, 0); tick();
    @(negedge clk);
    #1;
    checks++;
    if (a_sc !== 16'd301) begin
      errors++;
      $display("FAIL final_a_sc: got %0d expected 301", a_sc);
    end
    checks++;
    if (b_sc !== 8'd255) begin
      errors++;
      $display("FAIL final_b_sc: got %0d expected 255", b_sc);
    end
    checks++;
    if (a_ctl !== IDLE) begin
      errors++;
      $display("FAIL final_a_ctl: got %b", a_ctl);
    end
    checks++;
    if (b_ctl !== IDLE) begin
      errors++;
      $display("FAIL final_b_ctl: got %b", b_ctl);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage WISC-SP22 core. It owns the `stall`/`nop`/`flush` controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It detects load-use hazards, squashes wrong-path instructions after an EX-resolved redirect, and freezes the pipeline around multi-cycle instruction- and data-memory accesses. Registered state tracks stall countdowns, redirects deferred by a fetch stall, and the terminal halt.

## Interface
- `LU_CYC`, default 1: bubbles inserted per load-use hazard. Legal values 1..3. Set to 2 when no MEM->EX forwarding exists.
- `CNT_W`, default 16: width of the saturating performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `id_rs`, `id_rt` in 3 each: source registers of the instruction in ID.
- `id_rs_vld`, `id_rt_vld` in 1 each: the corresponding source is actually read.
- `ex_wr_reg` in 3: destination register of the instruction in EX.
- `ex_memread` in 1: the instruction in EX is a load.
- `ex_redirect` in 1: branch or jump taken in EX this cycle.
- `imem_stall` in 1: instruction memory is busy; the fetch result is not valid.
- `dmem_stall` in 1: data memory is busy; the MEM stage cannot complete.
- `wb_halt` in 1: a HALT instruction is in WB.
- `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` out 1 each: hold the register; no load.
- `ifid_flush` out 1: load a NOP into IF_ID.
- `idex_nop` out 1: kill the write/memory/halt/dump controls entering ID_EX.
- `memwb_nop` out 1: kill the controls entering MEM_WB.
- `halted` out 1: the core is stopped.
- `state` out 2: `RUN`=0, `LU`=1, `DWAIT`=2, `HALT`=3.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: saturating event counters.

## Operation
- The FSM state, the load-use countdown `lu_cnt` (2 bits), the deferred-redirect flag `rd_pend`, and both counters are registered. All outputs except the counters are combinational from the state and the current inputs.
- Hazard term: `lu_hit = ex_memread & ((id_rs_vld & id_rs==ex_wr_reg) | (id_rt_vld & id_rt==ex_wr_reg))`. r0 is an ordinary register and is compared like any other.
- Priority, highest first: HALT, dmem_stall, ex_redirect, load-use, imem_stall.

State behaviour:
- `HALT`: all four stalls are 1, and `idex_nop`, `memwb_nop` and `halted` are 1. The state is absorbing until reset.
- `dmem_stall` (any non-HALT state): all four stalls are 1 and `memwb_nop`=1. The next state is `DWAIT`. `lu_cnt` and `rd_pend` are frozen.
- `DWAIT` with `dmem_stall`=0: behaves as `RUN` for this cycle and returns to `RUN`. If `lu_cnt`!=0, it returns to `LU` instead.
- `ex_redirect`: `ifid_flush`=1 and `idex_nop`=1, with no stalls. A redirect overrides a simultaneous `lu_hit`, because the load-use consumer is wrong-path. It also clears `lu_cnt`.
- If `imem_stall`=1 in the same cycle as the redirect, `rd_pend` is set. While `rd_pend`=1 and `imem_stall`=1, `pc_stall`=0, so the redirect target is accepted. The cycle `imem_stall` drops, `ifid_flush`=1 and `rd_pend` clears.
- `RUN` with `lu_hit`: `pc_stall`=1, `ifid_stall`=1 and `idex_nop`=1. `lu_cnt` is loaded with `LU_CYC-1`. The next state is `LU` if `LU_CYC`>1, otherwise `RUN`.
- `LU`: the same outputs as the load-use case. `lu_cnt` decrements, and the FSM returns to `RUN` when `lu_cnt` reaches 0.
- `imem_stall` only: `pc_stall`=1, `ifid_flush`=1 and `idex_nop` follows a bubble. ID_EX and later stages keep flowing.
- `wb_halt`=1 with no `dmem_stall`: the next state is `HALT`.
- `stall_cnt` increments in any cycle where `pc_stall`=1 and the state is not `HALT`.
- `flush_cnt` increments in any cycle where `ifid_flush` is caused by a redirect, either direct or deferred.
- Both counters saturate at all-ones.

## Timing
- Reset (`rst`=0 at a clock edge):
  - Registered values: state=`RUN`, `lu_cnt`=0, `rd_pend`=0, counters=0.
  - While `rst`=0: all stalls are 0; `ifid_flush`, `idex_nop` and `memwb_nop` are 1; `halted`=0.
  - Reset mid-stall or mid-HALT returns to `RUN` on the same edge.
- Load-use costs exactly `LU_CYC` bubbles. The consumer enters EX `LU_CYC`+1 cycles after first detection.
- A redirect costs 2 squashed slots (IF_ID and ID_EX) and zero stall cycles.
- `dmem_stall` asserted for N cycles adds exactly N frozen cycles. State is `DWAIT` from cycle 2 through N+1.
- Simultaneous `dmem_stall` and `ex_redirect`: the freeze wins. The redirect is still held in EX and is taken the first cycle after the freeze.

## Test plan
- Load-use: LD r3 in EX while ID reads r3 via rs, `LU_CYC`=1 -> one cycle of `pc_stall`=`ifid_stall`=`idex_nop`=1, then `RUN`. With `LU_CYC`=2 -> two cycles, passing through `LU`. The same case with `id_rs_vld`=0 -> no stall.
- Redirect and load-use together: `ex_redirect`=1 and `lu_hit`=1 -> `ifid_flush`=`idex_nop`=1, no stall, `flush_cnt`=1.
- Deferred redirect: `ex_redirect` with `imem_stall`=1 for 3 cycles -> `rd_pend` is held. `ifid_flush` pulses on the cycle `imem_stall` falls, then `rd_pend`=0.
- Data-memory freeze: `dmem_stall` for 4 cycles in the middle of an `LU` countdown -> all stalls are 1 and `memwb_nop`=1 for 4 cycles. `lu_cnt` is preserved, then the FSM resumes in `LU`. `stall_cnt` increases by 4 plus the remaining load-use cycles.
- Halt: `wb_halt`=1 -> `halted`=1 and all stalls are 1 from the next cycle. Drive `rst`=0 for one edge -> state=`RUN` and counters=0.
- Saturation: preload 300 stall cycles with `CNT_W`=8 -> `stall_cnt`=255 and holds there.
